// File: rtl/ring_painter_pkg.sv
// Shared types and colour constants for the ring painter and its ring animators.
package ring_painter_pkg;

    typedef enum logic {
        RING_GROW   = 1'b0,
        RING_SHRINK = 1'b1
    } ring_dir_e;

    localparam logic [2:0] BORDER_RGB = 3'b100;
    localparam logic [2:0] BLANK_RGB  = 3'b000;

    // Colour driven by ring idx: ring0 green, ring1 blue, ring2 cyan.
    function automatic logic [2:0] ring_rgb(input int idx);
        case (idx)
            0:       return 3'b010;
            1:       return 3'b001;
            default: return 3'b011;
        endcase
    endfunction

endpackage

// File: rtl/ring_animator.sv
// One breathing ring: GROW/SHRINK direction FSM, radius register and squared bounds.
module ring_animator
    import ring_painter_pkg::*;
#(
    parameter int R_W    = 6,
    parameter int D2_W   = 15,
    parameter int R_MIN  = 4,
    parameter int R_MAX  = 24,
    parameter int R_INIT = 4,
    parameter int THICK  = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            step,
    output logic [D2_W-1:0] lo2,
    output logic [D2_W-1:0] hi2
);

    localparam logic [R_W-1:0]  RMIN_V  = R_W'(R_MIN);
    localparam logic [R_W-1:0]  RMAX_V  = R_W'(R_MAX);
    localparam logic [R_W-1:0]  RINIT_V = R_W'(R_INIT);
    localparam logic [D2_W-1:0] LO2_INIT = D2_W'(R_INIT * R_INIT);
    localparam logic [D2_W-1:0] HI2_INIT = D2_W'((R_INIT + THICK) * (R_INIT + THICK));

    ring_dir_e      dir_q, dir_d;
    logic [R_W-1:0] r_q, r_d;
    logic [D2_W-1:0] r_ext, rt_ext;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q <= RING_GROW;
            r_q   <= RINIT_V;
        end else begin
            dir_q <= dir_d;
            r_q   <= r_d;
        end
    end

    // NOTE: defaults first so no path through this block leaves a latch behind.
    always_comb begin
        dir_d = dir_q;
        r_d   = r_q;
        if (step && (R_MIN != R_MAX)) begin
            case (dir_q)
                RING_GROW: begin
                    if (r_q < RMAX_V) begin
                        r_d = r_q + R_W'(1);
                    end else begin
                        r_d   = r_q - R_W'(1);
                        dir_d = RING_SHRINK;
                    end
                end
                RING_SHRINK: begin
                    if (r_q > RMIN_V) begin
                        r_d = r_q - R_W'(1);
                    end else begin
                        r_d   = r_q + R_W'(1);
                        dir_d = RING_GROW;
                    end
                end
                default: dir_d = RING_GROW;
            endcase
        end
    end

    assign r_ext  = D2_W'(r_q);
    assign rt_ext = r_ext + D2_W'(THICK);

    // Bounds follow the radius one clock later and are the only thing the pixel compare sees.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lo2 <= LO2_INIT;
            hi2 <= HI2_INIT;
        end else begin
            lo2 <= r_ext * r_ext;
            hi2 <= rt_ext * rt_ext;
        end
    end

endmodule

// File: rtl/ring_painter.sv
// Painter stage: frame-change detect, step counter, per-ring animators and a 3-stage pixel pipeline.
module ring_painter
    import ring_painter_pkg::*;
#(
    parameter int COORD_W     = 6,
    parameter int PANEL_W     = 64,
    parameter int PANEL_H     = 64,
    parameter int N_RINGS     = 2,
    parameter int R_MIN       = 4,
    parameter int R_MAX       = 24,
    parameter int THICK       = 1,
    parameter int STEP_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [9:0]         frame,
    input  logic [7:0]         subframe,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [2:0]         rgb
);

    localparam int SQ_W  = 2 * COORD_W + 2;
    localparam int D2_W  = 2 * COORD_W + 3;
    localparam int R_W   = $clog2(R_MAX + THICK + 1);
    localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int R_GAP = (R_MAX - R_MIN) / N_RINGS;

    localparam logic [COORD_W:0]   CX_V     = (COORD_W + 1)'(PANEL_W / 2);
    localparam logic [COORD_W:0]   CY_V     = (COORD_W + 1)'(PANEL_H / 2);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(PANEL_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(PANEL_H - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_FRAMES - 1);

    logic unused_subframe;
    assign unused_subframe = ^subframe;

    // ---------------- frame boundary and step generation ----------------
    logic [9:0]       frame_q;
    logic             primed;
    logic             boundary;
    logic             step;
    logic [CNT_W-1:0] step_cnt;

    // primed masks the first clock after release, making frame_q equal frame at that point.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            primed  <= 1'b0;
            frame_q <= '0;
        end else begin
            primed  <= 1'b1;
            frame_q <= frame;
        end
    end

    assign boundary = primed && (frame != frame_q);
    assign step     = boundary && (step_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step_cnt <= '0;
        end else if (boundary) begin
            step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + CNT_W'(1);
        end
    end

    // ---------------- ring animators ----------------
    logic [D2_W-1:0] lo2 [N_RINGS];
    logic [D2_W-1:0] hi2 [N_RINGS];

    for (genvar i = 0; i < N_RINGS; i++) begin : g_ring
        ring_animator #(
            .R_W    (R_W),
            .D2_W   (D2_W),
            .R_MIN  (R_MIN),
            .R_MAX  (R_MAX),
            .R_INIT (R_MIN + i * R_GAP),
            .THICK  (THICK)
        ) u_anim (
            .clk    (clk),
            .resetn (resetn),
            .step   (step),
            .lo2    (lo2[i]),
            .hi2    (hi2[i])
        );
    end

    // ---------------- pixel pipeline ----------------
    logic signed [COORD_W:0] dx1, dy1;
    logic                    border1, border2, border_d;
    logic signed [SQ_W-1:0]  dx_ext, dy_ext;
    logic [SQ_W-1:0]         dx2, dy2;
    logic [D2_W-1:0]         d2;
    logic [2:0]              rgb_d;

    assign border_d = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
    assign dx_ext   = SQ_W'(dx1);
    assign dy_ext   = SQ_W'(dy1);
    assign d2       = D2_W'(dx2) + D2_W'(dy2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx1     <= '0;
            dy1     <= '0;
            border1 <= 1'b0;
            dx2     <= '0;
            dy2     <= '0;
            border2 <= 1'b0;
            rgb     <= BLANK_RGB;
        end else begin
            dx1     <= CX_V - {1'b0, x};
            dy1     <= CY_V - {1'b0, y};
            border1 <= border_d;
            dx2     <= dx_ext * dx_ext;
            dy2     <= dy_ext * dy_ext;
            border2 <= border1;
            rgb     <= rgb_d;
        end
    end

    // Walk rings from highest index down so the lowest-index hit wins; border overrides all.
    always_comb begin
        rgb_d = BLANK_RGB;
        for (int i = N_RINGS - 1; i >= 0; i--) begin
            if ((d2 >= lo2[i]) && (d2 < hi2[i])) begin
                rgb_d = ring_rgb(i);
            end
        end
        if (border2) begin
            rgb_d = BORDER_RGB;
        end
    end

endmodule

// File: tb/tb_ring_painter.sv
// Self-checking bench for ring_painter: radius/direction model plus distance-based colour reference.
`timescale 1ns/1ps
module tb_ring_painter;

    localparam int NR   = 2;
    localparam int RMIN = 4;
    localparam int RMAX = 24;
    localparam int THK  = 1;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] frame = '0;
    logic [7:0] subframe = '0;
    logic [5:0] x = 6'd32;
    logic [5:0] y = 6'd32;
    logic [2:0] rgb;

    int n_checks = 0;
    int n_errors = 0;

    int         m_r [3];
    bit         m_grow [3];
    int         m_cnt;
    logic [9:0] cur_frame = '0;
    logic [2:0] ring_col [3] = '{3'b010, 3'b001, 3'b011};

    ring_painter dut (
        .clk      (clk),
        .resetn   (resetn),
        .frame    (frame),
        .subframe (subframe),
        .x        (x),
        .y        (y),
        .rgb      (rgb)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_r[i]    = RMIN + i * ((RMAX - RMIN) / NR);
            m_grow[i] = 1'b1;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_boundary();
        m_cnt++;
        if (m_cnt < STEP) return;
        m_cnt = 0;
        for (int i = 0; i < NR; i++) begin
            if (RMIN == RMAX) continue;
            if (m_grow[i]) begin
                if (m_r[i] < RMAX) m_r[i]++;
                else begin m_r[i]--; m_grow[i] = 1'b0; end
            end else begin
                if (m_r[i] > RMIN) m_r[i]--;
                else begin m_r[i]++; m_grow[i] = 1'b1; end
            end
        end
    endfunction

    function automatic logic [2:0] exp_rgb(input int px, input int py);
        int d2;
        if (px == 0 || px == 63 || py == 0 || py == 63) return 3'b100;
        d2 = (32 - px) * (32 - px) + (32 - py) * (32 - py);
        for (int i = 0; i < NR; i++) begin
            if (d2 >= m_r[i] * m_r[i] && d2 < (m_r[i] + THK) * (m_r[i] + THK)) return ring_col[i];
        end
        return 3'b000;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic frame_set(input logic [9:0] v);
        @(posedge clk); #1;
        frame = v;
        if (v != cur_frame) model_boundary();
        cur_frame = v;
    endtask

    task automatic frame_tick();
        frame_set(cur_frame + 10'd1);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
    endtask

    task automatic align_step_cnt();
        while (m_cnt != 0) frame_tick();
        settle();
    endtask

    task automatic get_pixel(input int px, input int py, output logic [2:0] got);
        logic [31:0] vx, vy;
        vx = px;
        vy = py;
        @(posedge clk); #1;
        x = vx[5:0];
        y = vy[5:0];
        repeat (3) @(posedge clk);
        #1 got = rgb;
    endtask

    task automatic cmp_pixel(input string name, input int px, input int py, input logic [2:0] req);
        logic [2:0] got;
        get_pixel(px, py, got);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s (x=%0d y=%0d): got %b expected %b", name, px, py, got, req);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        x = 6'd32;
        y = 6'd32;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rgb !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_rgb cycle %0d: got %b expected 000", i, rgb);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        cmp_pixel("reset_ring0_r4", 36, 32, 3'b010);
        cmp_pixel("reset_ring1_r14", 46, 32, 3'b001);
        cmp_pixel("reset_ring1_outer", 47, 32, 3'b000);
    endtask

    task automatic test_latency();
        x = 6'd32; y = 6'd32;
        repeat (4) @(posedge clk);
        #1 x = 6'd0; y = 6'd5;
        @(posedge clk); #1 x = 6'd32; y = 6'd32;
        @(posedge clk); #1;
        n_checks++;
        if (rgb !== 3'b000) begin
            n_errors++;
            $display("FAIL latency_n+2: got %b expected 000", rgb);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rgb !== 3'b100) begin
            n_errors++;
            $display("FAIL latency_n+3: got %b expected 100", rgb);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rgb !== 3'b000) begin
            n_errors++;
            $display("FAIL latency_n+4: got %b expected 000", rgb);
        end
    endtask

    task automatic test_ring_hit();
        cmp_pixel("hit_x36", 36, 32, 3'b010);
        cmp_pixel("hit_x37", 37, 32, 3'b000);
        cmp_pixel("hit_centre", 32, 32, 3'b000);
        cmp_pixel("hit_x28", 28, 32, 3'b010);
        cmp_pixel("hit_y18", 32, 18, 3'b001);
        cmp_pixel("border_x63", 63, 40, 3'b100);
        cmp_pixel("border_y0", 20, 0, 3'b100);
    endtask

    task automatic test_animation();
        int guard;
        frame_tick(); frame_tick(); settle();
        cmp_pixel("anim_r5_x37", 37, 32, 3'b010);
        cmp_pixel("anim_r5_x36", 36, 32, 3'b000);
        guard = 0;
        while (m_r[0] != RMAX && guard < 200) begin frame_tick(); guard++; end
        settle();
        cmp_pixel("anim_r24", 32 + m_r[0], 32, exp_rgb(32 + m_r[0], 32));
        cmp_pixel("anim_r24_x56", 56, 32, 3'b010);
        frame_tick(); frame_tick(); settle();
        cmp_pixel("anim_r23_x55", 55, 32, 3'b010);
        cmp_pixel("anim_r23_x56", 56, 32, 3'b000);
        frame_tick(); frame_tick(); settle();
        cmp_pixel("anim_shrink_x54", 54, 32, 3'b010);
        guard = 0;
        while (m_r[0] != RMIN && guard < 200) begin frame_tick(); guard++; end
        settle();
        cmp_pixel("anim_rmin", 36, 32, exp_rgb(36, 32));
        frame_tick(); frame_tick(); settle();
        cmp_pixel("anim_reverse_x37", 37, 32, exp_rgb(37, 32));
        cmp_pixel("anim_ring1", 32, 32 - m_r[1], exp_rgb(32, 32 - m_r[1]));
    endtask

    task automatic test_frame_wrap();
        int r_before;
        align_step_cnt();
        frame_set(10'd1023);
        r_before = m_r[0];
        frame_set(10'd0);
        settle();
        cmp_pixel("wrap_new_radius", 32 + m_r[0], 32, exp_rgb(32 + m_r[0], 32));
        cmp_pixel("wrap_old_radius", 32 + r_before, 32, exp_rgb(32 + r_before, 32));
        repeat (1000) @(posedge clk);
        cmp_pixel("static_ring0", 32, 32 + m_r[0], exp_rgb(32, 32 + m_r[0]));
        cmp_pixel("static_ring1", 32 - m_r[1], 32, exp_rgb(32 - m_r[1], 32));
    endtask

    task automatic test_back_to_back();
        align_step_cnt();
        for (int i = 0; i < 4; i++) frame_tick();
        settle();
        cmp_pixel("b2b_ring0", 32 + m_r[0], 32, exp_rgb(32 + m_r[0], 32));
        cmp_pixel("b2b_ring1", 32, 32 + m_r[1], exp_rgb(32, 32 + m_r[1]));
    endtask

    task automatic test_async_reset();
        frame_tick(); frame_tick(); frame_tick(); settle();
        cmp_pixel("pre_reset_border", 0, 0, 3'b100);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (rgb !== 3'b000) begin
            n_errors++;
            $display("FAIL async_reset_rgb: got %b expected 000", rgb);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        cmp_pixel("post_reset_ring0", 36, 32, 3'b010);
        cmp_pixel("post_reset_ring1", 32, 46, 3'b001);
        frame_tick(); settle();
        cmp_pixel("post_reset_no_partial", 36, 32, 3'b010);
        frame_tick(); settle();
        cmp_pixel("post_reset_step", 37, 32, exp_rgb(37, 32));
    endtask

    task automatic test_random_stream();
        logic [2:0] q[$];
        logic [2:0] req;
        int px, py;
        for (int round = 0; round < 12; round++) begin
            int ticks = $urandom_range(0, 5);
            for (int t = 0; t < ticks; t++) frame_tick();
            settle();
            q.delete();
            for (int k = 0; k < 43; k++) begin
                @(posedge clk); #1;
                if (q.size() == 3) begin
                    req = q.pop_front();
                    n_checks++;
                    if (rgb !== req) begin
                        n_errors++;
                        $display("FAIL stream round %0d beat %0d: got %b expected %b", round, k, rgb, req);
                    end
                end
                if (k < 40) begin
                    px = (($urandom & 3) == 0) ? 32 + m_r[$urandom_range(0, NR - 1)] : $urandom_range(0, 63);
                    py = $urandom_range(0, 63);
                    if (px > 32 && ($urandom & 1)) py = 32;
                    x = 6'(px);
                    y = 6'(py);
                    subframe = 8'($urandom);
                    q.push_back(exp_rgb(px, py));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_ring_hit();
        test_animation();
        test_frame_wrap();
        test_back_to_back();
        test_async_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
